axil_mem_scrub: RTL and testbench

- AXI-Lite master sequencer that initialises and self-checks the 256-word AXI-Lite register/memory slave on the PCIe AXI side.
- On `start` it writes a deterministic pattern to NWORDS consecutive words, then reads every word back and counts mismatches and non-OKAY responses.
- Sits in front of the slave, or on a mux port ahead of it, during bring-up and after reset.

---
 rtl/axil_mem_scrub.sv | 174 +++++++++++++++++
 tb/tb_axil_mem_scrub.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/axil_mem_scrub.sv
// AXI-Lite scrub master: writes DATA_SEED^idx to NWORDS words, reads them back, counts bad data/responses.
// One transaction in flight at a time; define AXIL_SCRUB_INVERT_PASS_EN to add a second pass with inverted data.
module axil_mem_scrub #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned NWORDS    = 256,
  parameter logic [31:0] DATA_SEED = 32'h1234_5678
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [15:0] err_cnt,
  output logic [31:0] m_axi_awaddr,
  output logic        m_axi_awvalid,
  input  logic        m_axi_awready,
  output logic [31:0] m_axi_wdata,
  output logic [3:0]  m_axi_wstrb,
  output logic        m_axi_wvalid,
  input  logic        m_axi_wready,
  input  logic [1:0]  m_axi_bresp,
  input  logic        m_axi_bvalid,
  output logic        m_axi_bready,
  output logic [31:0] m_axi_araddr,
  output logic        m_axi_arvalid,
  input  logic        m_axi_arready,
  input  logic [31:0] m_axi_rdata,
  input  logic [1:0]  m_axi_rresp,
  input  logic        m_axi_rvalid,
  output logic        m_axi_rready
);

  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, FIN} state_t;

  localparam logic [15:0] LAST_IDX = 16'(NWORDS - 1);

  state_t      state, state_nxt;
  logic [15:0] idx, idx_nxt;
  logic        pass, pass_nxt, pass_last;
  logic        aw_done, w_done;
  logic        aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic        last;
  logic [31:0] rd_exp;
  logic        b_inc;
  logic [1:0]  rd_inc;
  logic [16:0] err_sum;

  function automatic logic [31:0] word_addr(input logic [15:0] i);
    return BASE_ADDR + {14'd0, i, 2'b00};
  endfunction

  function automatic logic [31:0] word_data(input logic [15:0] i, input logic inv);
    logic [31:0] p;
    p = DATA_SEED ^ {16'd0, i};
    return inv ? ~p : p;
  endfunction

  assign aw_hs  = m_axi_awvalid && m_axi_awready;
  assign w_hs   = m_axi_wvalid  && m_axi_wready;
  assign b_hs   = m_axi_bvalid  && m_axi_bready;
  assign ar_hs  = m_axi_arvalid && m_axi_arready;
  assign r_hs   = m_axi_rvalid  && m_axi_rready;
  assign last   = (idx == LAST_IDX);
  assign rd_exp = word_data(idx, pass);
  assign m_axi_wstrb = 4'hF;

`ifdef AXIL_SCRUB_INVERT_PASS_EN
  assign pass_last = pass;
  always_comb begin
    pass_nxt = pass;
    if (state == IDLE && start) pass_nxt = 1'b0;
    else if (r_hs && last)      pass_nxt = 1'b1;
  end
`else
  assign pass_last = 1'b1;
  assign pass_nxt  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = WR_REQ;
      WR_REQ:  if ((aw_done || aw_hs) && (w_done || w_hs)) state_nxt = WR_RESP;
      WR_RESP: if (b_hs) state_nxt = last ? RD_REQ : WR_REQ;
      RD_REQ:  if (ar_hs) state_nxt = RD_RESP;
      RD_RESP: if (r_hs) state_nxt = !last ? RD_REQ : (pass_last ? FIN : WR_REQ);
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    m_axi_awvalid = 1'b0;
    m_axi_wvalid  = 1'b0;
    m_axi_bready  = 1'b0;
    m_axi_arvalid = 1'b0;
    m_axi_rready  = 1'b0;
    busy          = 1'b0;
    done          = 1'b0;
    case (state)
      WR_REQ: begin
        m_axi_awvalid = !aw_done;
        m_axi_wvalid  = !w_done;
        busy          = 1'b1;
      end
      WR_RESP: begin
        m_axi_bready = 1'b1;
        busy         = 1'b1;
      end
      RD_REQ: begin
        m_axi_arvalid = 1'b1;
        busy          = 1'b1;
      end
      RD_RESP: begin
        m_axi_rready = 1'b1;
        busy         = 1'b1;
      end
      FIN:     done = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    idx_nxt = idx;
    if (state == IDLE && start) idx_nxt = 16'd0;
    else if (b_hs || r_hs)      idx_nxt = last ? 16'd0 : idx + 16'd1;
  end

  // A read can be both wrong and non-OKAY, so one beat may add two.
  assign b_inc   = b_hs && (m_axi_bresp != 2'b00);
  assign rd_inc  = r_hs ? ({1'b0, m_axi_rresp != 2'b00} + {1'b0, m_axi_rdata != rd_exp}) : 2'd0;
  assign err_sum = {1'b0, err_cnt} + {16'd0, b_inc} + {15'd0, rd_inc};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx          <= 16'd0;
      pass         <= 1'b0;
      aw_done      <= 1'b0;
      w_done       <= 1'b0;
      err_cnt      <= 16'd0;
      m_axi_awaddr <= 32'd0;
      m_axi_wdata  <= 32'd0;
      m_axi_araddr <= 32'd0;
    end else begin
      idx  <= idx_nxt;
      pass <= pass_nxt;

      if (state == IDLE && start) err_cnt <= 16'd0;
      else                        err_cnt <= err_sum[16] ? 16'hFFFF : err_sum[15:0];

      // Each channel remembers its own handshake so its valid drops independently.
      if (state == WR_REQ && state_nxt == WR_REQ) begin
        aw_done <= aw_done || aw_hs;
        w_done  <= w_done  || w_hs;
      end else begin
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end

      if (state_nxt == WR_REQ && state != WR_REQ) begin
        m_axi_awaddr <= word_addr(idx_nxt);
        m_axi_wdata  <= word_data(idx_nxt, pass_nxt);
      end
      if (state_nxt == RD_REQ && state != RD_REQ)
        m_axi_araddr <= word_addr(idx_nxt);
    end
  end

endmodule

// File: tb/tb_axil_mem_scrub.sv
// Directed bench for axil_mem_scrub: 4-word run against a behavioural AXI-Lite memory with knobs
// for per-channel ready delay, error responses and read corruption.
module tb_axil_mem_scrub;

`ifdef AXIL_SCRUB_INVERT_PASS_EN
  localparam int NP = 2;
`else
  localparam int NP = 1;
`endif
  localparam int NW      = 4;
  localparam int EXP_CYC = NP * 16 + 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        busy, done;
  logic [15:0] err_cnt;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [3:0]  wstrb;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [1:0]  bresp, rresp;

  always #5 clk = ~clk;

  axil_mem_scrub #(.BASE_ADDR(32'h0), .NWORDS(NW), .DATA_SEED(32'h1234_5678)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .err_cnt(err_cnt),
    .m_axi_awaddr(awaddr), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
    .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wvalid(wvalid), .m_axi_wready(wready),
    .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
    .m_axi_araddr(araddr), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
    .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rvalid(rvalid), .m_axi_rready(rready)
  );

  // Slave knobs, driven from the stimulus process only.
  int   aw_dly = 0, w_dly = 0;
  logic bresp_bad = 1'b0;
  int   corrupt_idx = -1, rresp_bad_idx = -1;
  logic scramble = 1'b0;

  logic [31:0] mem [256];
  logic        s_aw_got, s_w_got;
  logic [31:0] s_aw_addr, s_w_data;
  int          aw_wait, w_wait;
  logic        aw_hs, w_hs, wr_fire;
  logic [31:0] wr_a, wr_d;

  assign awready = !s_aw_got && !bvalid && (aw_wait >= aw_dly);
  assign wready  = !s_w_got  && !bvalid && (w_wait  >= w_dly);
  assign arready = !rvalid;
  assign aw_hs   = awvalid && awready;
  assign w_hs    = wvalid && wready;
  assign wr_fire = (s_aw_got || aw_hs) && (s_w_got || w_hs);
  assign wr_a    = s_aw_got ? s_aw_addr : awaddr;
  assign wr_d    = s_w_got ? s_w_data : wdata;

  always @(posedge clk) begin
    if (!rst_n) begin
      s_aw_got <= 1'b0; s_w_got <= 1'b0; aw_wait <= 0; w_wait <= 0;
      s_aw_addr <= 32'h0; s_w_data <= 32'h0;
      bvalid <= 1'b0; bresp <= 2'b00; rvalid <= 1'b0; rresp <= 2'b00; rdata <= 32'h0;
    end else begin
      if (scramble)
        for (int i = 0; i < 256; i++) mem[i] <= 32'hA5A5_0000 | 32'(i);
      if (aw_hs) begin s_aw_got <= 1'b1; s_aw_addr <= awaddr; aw_wait <= 0; end
      else if (awvalid) aw_wait <= aw_wait + 1;
      if (w_hs) begin s_w_got <= 1'b1; s_w_data <= wdata; w_wait <= 0; end
      else if (wvalid) w_wait <= w_wait + 1;
      if (wr_fire) begin
        mem[wr_a[9:2]] <= wr_d;
        bvalid   <= 1'b1;
        bresp    <= bresp_bad ? 2'b10 : 2'b00;
        s_aw_got <= 1'b0;
        s_w_got  <= 1'b0;
      end
      if (bvalid && bready) bvalid <= 1'b0;
      if (arvalid && arready) begin
        rvalid <= 1'b1;
        rdata  <= (int'(araddr[9:2]) == corrupt_idx) ? 32'h0 : mem[araddr[9:2]];
        rresp  <= (int'(araddr[9:2]) == rresp_bad_idx) ? 2'b10 : 2'b00;
      end
      if (rvalid && rready) rvalid <= 1'b0;
    end
  end

  // Handshake counters and protocol monitor (valid stability, independent drop).
  int          n_aw = 0, n_w = 0, n_b = 0, n_ar = 0, n_r = 0, n_bv = 0, n_viol = 0;
  logic        aw_pend = 1'b0, w_pend = 1'b0;
  logic [31:0] aw_pend_a = 32'h0, w_pend_d = 32'h0;

  always @(posedge clk) begin
    if (aw_hs) n_aw <= n_aw + 1;
    if (w_hs)  n_w  <= n_w + 1;
    if (bvalid && bready)   n_b  <= n_b + 1;
    if (bvalid)             n_bv <= n_bv + 1;
    if (arvalid && arready) n_ar <= n_ar + 1;
    if (rvalid && rready)   n_r  <= n_r + 1;
    if (!rst_n) begin
      aw_pend <= 1'b0; w_pend <= 1'b0;
    end else begin
      if ((aw_pend && (!awvalid || awaddr != aw_pend_a)) || (w_pend && (!wvalid || wdata != w_pend_d)) ||
          (awvalid && s_aw_got) || (wvalid && s_w_got))
        n_viol <= n_viol + 1;
      aw_pend <= awvalid && !awready; aw_pend_a <= awaddr;
      w_pend  <= wvalid && !wready;   w_pend_d  <= wdata;
    end
  end

  int checks = 0, errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  logic [31:0] exp_mem [NW];

  task automatic check_mem(input string tag);
    for (int i = 0; i < NW; i++) check(tag, 64'(mem[i]), 64'(exp_mem[i]));
  endtask

  task automatic run_scrub(input int mid_start, output int cyc);
    scramble = 1'b1; @(negedge clk); scramble = 1'b0;
    start = 1'b1; @(negedge clk); start = 1'b0;
    cyc = 1;
    while (!done && cyc < 1000) begin
      start = (cyc == mid_start);
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    if (!done) check("done_timeout", 64'(cyc), 64'(EXP_CYC));
  endtask

  int cyc, b_aw, b_w, b_b, b_bv, b_ar, b_r, b_viol, guard;

  task automatic snap();
    b_aw = n_aw; b_w = n_w; b_b = n_b; b_bv = n_bv; b_ar = n_ar; b_r = n_r; b_viol = n_viol;
  endtask

  task automatic check_counts(input string tag);
    check({tag, "_aw"}, 64'(n_aw - b_aw), 64'(NW * NP));
    check({tag, "_w"},  64'(n_w - b_w),   64'(NW * NP));
    check({tag, "_b"},  64'(n_b - b_b),   64'(NW * NP));
    check({tag, "_bv"}, 64'(n_bv - b_bv), 64'(NW * NP));
    check({tag, "_ar"}, 64'(n_ar - b_ar), 64'(NW * NP));
    check({tag, "_r"},  64'(n_r - b_r),   64'(NW * NP));
    check({tag, "_viol"}, 64'(n_viol - b_viol), 64'd0);
  endtask

  initial begin
`ifdef AXIL_SCRUB_INVERT_PASS_EN
    exp_mem = '{32'hEDCB_A987, 32'hEDCB_A986, 32'hEDCB_A985, 32'hEDCB_A984};
`else
    exp_mem = '{32'h1234_5678, 32'h1234_5679, 32'h1234_567A, 32'h1234_567B};
`endif
    repeat (3) @(negedge clk);
    check("rst_valids", {59'd0, awvalid, wvalid, bready, arvalid, rready}, 64'd0);
    check("rst_busy_done", {62'd0, busy, done}, 64'd0);
    check("rst_err", 64'(err_cnt), 64'd0);
    check("rst_addr_data", {awaddr, wdata}, 64'd0);
    check("rst_araddr", 64'(araddr), 64'd0);
    check("rst_wstrb", 64'(wstrb), 64'hF);
    rst_n = 1'b1;
    @(negedge clk);

    // Zero-wait slave.
    snap();
    run_scrub(-1, cyc);
    check("zw_cycles", 64'(cyc), 64'(EXP_CYC));
    check("zw_done_busy", {62'd0, busy, done}, 64'b01);
    check("zw_err", 64'(err_cnt), 64'd0);
    check_counts("zw");
    check_mem("zw_mem");
    @(negedge clk);
    check("zw_done_pulse", {62'd0, busy, done}, 64'b00);

    // AW lags W by 3 cycles, then W lags AW.
    aw_dly = 3; w_dly = 0;
    snap(); run_scrub(-1, cyc);
    check("awlag_err", 64'(err_cnt), 64'd0);
    check_counts("awlag");
    check_mem("awlag_mem");
    aw_dly = 0; w_dly = 3;
    snap(); run_scrub(-1, cyc);
    check("wlag_err", 64'(err_cnt), 64'd0);
    check_counts("wlag");
    check_mem("wlag_mem");
    w_dly = 0;

    // Word 2 read back as 0, word 3 with SLVERR: two errors per readback.
    corrupt_idx = 2; rresp_bad_idx = 3;
    run_scrub(-1, cyc);
    check("rderr_err", 64'(err_cnt), 64'(2 * NP));
    corrupt_idx = -1; rresp_bad_idx = -1;

    // Every write answered with SLVERR; a start while busy must be ignored.
    bresp_bad = 1'b1;
    snap(); run_scrub(5, cyc);
    check("berr_err", 64'(err_cnt), 64'(NW * NP));
    check("berr_cycles", 64'(cyc), 64'(EXP_CYC));
    check("berr_aw", 64'(n_aw - b_aw), 64'(NW * NP));
    repeat (5) @(negedge clk);
    check("berr_hold", 64'(err_cnt), 64'(NW * NP));
    check("berr_idle", {62'd0, busy, done}, 64'b00);

    // Reset during RD_RESP of word 1.
    start = 1'b1; @(negedge clk); start = 1'b0;
    guard = 0;
    while (!(rready && araddr == 32'h4) && guard < 200) begin @(negedge clk); guard++; end
    check("mid_reached", {63'd0, rready}, 64'd1);
    check("mid_err_before", 64'(err_cnt), 64'(NW));
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_valids", {59'd0, awvalid, wvalid, bready, arvalid, rready}, 64'd0);
    check("mid_busy_done", {62'd0, busy, done}, 64'd0);
    check("mid_err", 64'(err_cnt), 64'd0);
    rst_n = 1'b1; bresp_bad = 1'b0;
    @(negedge clk);
    snap(); run_scrub(-1, cyc);
    check("rerun_cycles", 64'(cyc), 64'(EXP_CYC));
    check("rerun_err", 64'(err_cnt), 64'd0);
    check_counts("rerun");
    check_mem("rerun_mem");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
